// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// seg7_scan_ctrl
// ----------------------------------------------------------------------------
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Each scan slot selects one BCD nibble for the downstream
// BCD-to-7-segment decoder and drives the matching active-low anode. Every
// slot opens with a blanking gap (all anodes off) so the previous digit's
// segment pattern cannot ghost onto the next digit.
//
// Slot timing (cnt counts within a slot):
//   BLANK : cnt = 0 .. BLANK_CYC-1         an = 4'hF, bcd_out = BLANK_CODE
//   DRIVE : cnt = BLANK_CYC .. SLOT_CYC-1  selected digit lit (or dark)
// A frame is four slots (digit 0 first), exactly 4*SLOT_CYC cycles long.
//
// Display inputs are captured into shadow registers once per frame, at the
// end of the frame-boundary cycle, so a frame never shows a torn value.
// blink_phase is sampled live on each BLANK->DRIVE edge; because the outputs
// are registered and only updated on state entry, it is constant per slot.
//
// Parameters:
//   SLOT_CYC    clk cycles per digit slot; must be > BLANK_CYC
//   BLANK_CYC   clk cycles of blanking at the start of each slot; >= 1
//   BLANK_CODE  decoder code that lights no segments
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   digits_in    in   16  digit3..digit0 nibbles ([15:12] = digit3, MSD)
//                         0-9 digits, 14 = A+DP, 15 = P+DP
//   dig_en       in   4   per-digit enable; 0 = digit dark
//   lz_suppress  in   1   1 = blank leading zeros on digits 3..1
//   blink_mask   in   4   per-digit blink select
//   blink_phase  in   1   1 = hide digits whose blink_mask bit is set
//   bcd_out      out  4   nibble to the decoder
//   an           out  4   anode drive, active low, one-hot-low or 4'hF
//   slot_idx     out  2   digit currently scanned (0..3)
//   frame_start  out  1   one-cycle pulse, first cycle of slot 0
// ============================================================================
module seg7_scan_ctrl #(
    parameter int unsigned SLOT_CYC   = 100000,
    parameter int unsigned BLANK_CYC  = 1000,
    parameter logic [3:0]  BLANK_CODE = 4'hB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dig_en,
    input  logic        lz_suppress,
    input  logic [3:0]  blink_mask,
    input  logic        blink_phase,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic [1:0]  slot_idx,
    output logic        frame_start
);

    localparam int unsigned CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       slot_next;
    logic [3:0]       an_next;
    logic [3:0]       bcd_next;

    // Per-frame snapshot of the display inputs.
    logic [15:0]      sh_digits;
    logic [3:0]       sh_en;
    logic             sh_lz;
    logic [3:0]       sh_bmask;

    // ------------------------------------------------------------------------
    // Frame boundary
    // ------------------------------------------------------------------------
    logic frame_edge;
    assign frame_edge  = (state == ST_BLANK) && (slot_idx == 2'd0) && (cnt == '0);
    // Gated so the pulse marks the first live cycle, not the whole reset.
    assign frame_start = frame_edge & ~rst;

    // ------------------------------------------------------------------------
    // Leading-zero suppression chain, MSD downwards. Digit 0 is never
    // suppressed so an all-zero value still shows a single 0.
    // ------------------------------------------------------------------------
    logic       lzb3, lzb2, lzb1;
    logic [3:0] lzb;
    assign lzb3 = sh_lz & (sh_digits[15:12] == 4'd0);
    assign lzb2 = lzb3  & (sh_digits[11:8]  == 4'd0);
    assign lzb1 = lzb2  & (sh_digits[7:4]   == 4'd0);
    assign lzb  = {lzb3, lzb2, lzb1, 1'b0};

    // ------------------------------------------------------------------------
    // Digit selected by the current slot and its display decision
    // ------------------------------------------------------------------------
    logic [3:0] cur_digit;
    logic       cur_shown;
    logic [3:0] cur_mapped;
    logic [3:0] cur_an;

    assign cur_digit = sh_digits[{slot_idx, 2'b00} +: 4];
    assign cur_shown = sh_en[slot_idx] & ~lzb[slot_idx]
                     & ~(sh_bmask[slot_idx] & blink_phase);
    // Codes 10-13 have no glyph; they stay dark but keep their anode slot.
    assign cur_mapped = ((cur_digit >= 4'd10) && (cur_digit <= 4'd13))
                      ? BLANK_CODE : cur_digit;
    assign cur_an     = ~(4'b0001 << slot_idx);

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        slot_next  = slot_idx;
        an_next    = an;
        bcd_next   = bcd_out;

        unique case (state)
            ST_BLANK: begin
                an_next  = 4'hF;
                bcd_next = BLANK_CODE;
                if (cnt == BLANK_LAST) begin
                    state_next = ST_DRIVE;
                    if (cur_shown) begin
                        an_next  = cur_an;
                        bcd_next = cur_mapped;
                    end
                end
            end

            ST_DRIVE: begin
                // an/bcd_out hold for the whole DRIVE phase, so the decoder
                // input never moves while an anode is low.
                if (cnt == SLOT_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    slot_next  = slot_idx + 2'd1;
                    an_next    = 4'hF;
                    bcd_next   = BLANK_CODE;
                end
            end

            default: begin
                state_next = ST_BLANK;
                cnt_next   = '0;
                an_next    = 4'hF;
                bcd_next   = BLANK_CODE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            slot_idx <= 2'd0;
            an       <= 4'hF;
            bcd_out  <= BLANK_CODE;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            slot_idx <= slot_next;
            an       <= an_next;
            bcd_out  <= bcd_next;
        end
    end

    // NOTE: the shadows are plain registers, not a memory, so they are reset
    // to a known (all-zero) value like any other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_digits <= 16'h0000;
            sh_en     <= 4'h0;
            sh_lz     <= 1'b0;
            sh_bmask  <= 4'h0;
        end else if (frame_edge) begin
            sh_digits <= digits_in;
            sh_en     <= dig_en;
            sh_lz     <= lz_suppress;
            sh_bmask  <= blink_mask;
        end
    end

    // At most one anode may ever be driven.
    a_one_anode : assert property (@(posedge clk) disable iff (rst) $onehot0(~an));

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// tb_seg7_scan_ctrl
// ----------------------------------------------------------------------------
// Runs seg7_scan_ctrl with SLOT_CYC=8, BLANK_CYC=2. Stimulus sets the display
// inputs, waits for frame_start and queues the hand-computed slot results for
// that frame (slot, anode, bcd). A monitor watches every cycle: it checks the
// blanking gap, pops one expectation per slot on the first DRIVE cycle, and
// checks that an/bcd_out stay put for the rest of the slot, that each slot is
// exactly SLOT_CYC cycles and that frame_start fires only at slot 0 entry.
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in;
    logic [3:0]  dig_en;
    logic        lz_suppress;
    logic [3:0]  blink_mask;
    logic        blink_phase;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic [1:0]  slot_idx;
    logic        frame_start;

    seg7_scan_ctrl #(
        .SLOT_CYC   (SLOT),
        .BLANK_CYC  (BLANK),
        .BLANK_CODE (4'hB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .dig_en      (dig_en),
        .lz_suppress (lz_suppress),
        .blink_mask  (blink_mask),
        .blink_phase (blink_phase),
        .bcd_out     (bcd_out),
        .an          (an),
        .slot_idx    (slot_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] slot;
        logic [3:0] an;
        logic [3:0] bcd;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.slot = s;
        e.an   = a;
        e.bcd  = b;
        return e;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    int         lc = 0;
    logic [1:0] prev_slot = 2'd0;
    logic [1:0] nxt_slot;
    bit         in_rst = 1'b1;
    logic [3:0] held_an, held_bcd;
    exp_t       got;

    always @(negedge clk) begin
        if (rst) begin
            in_rst = 1'b1;
        end else begin
            if (in_rst || (slot_idx != prev_slot)) begin
                if (!in_rst) begin
                    nxt_slot = prev_slot + 2'd1;
                    check("slot_len", 16'(lc), 16'(SLOT - 1));
                    check("slot_order", 16'(slot_idx), 16'(nxt_slot));
                end
                check("frame_start_at_entry", 16'(frame_start), 16'(slot_idx == 2'd0));
                lc = 0;
            end else begin
                check("frame_start_mid", 16'(frame_start), 16'(0));
                lc++;
            end

            if (lc < BLANK) begin
                check("gap_an", 16'(an), 16'(4'hF));
                check("gap_bcd", 16'(bcd_out), 16'(4'hB));
            end else if (lc == BLANK) begin
                held_an  = an;
                held_bcd = bcd_out;
                if (q.size() > 0) begin
                    got = q.pop_front();
                    check("slot_idx", 16'(slot_idx), 16'(got.slot));
                    check("an", 16'(an), 16'(got.an));
                    check("bcd_out", 16'(bcd_out), 16'(got.bcd));
                end
            end else if (lc < SLOT) begin
                check("an_hold", 16'(an), 16'(held_an));
                check("bcd_hold", 16'(bcd_out), 16'(held_bcd));
            end else begin
                check("slot_len", 16'(lc), 16'(SLOT - 1));
            end

            prev_slot = slot_idx;
            in_rst    = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic set_in(input logic [15:0] d, input logic [3:0] en,
                          input logic lz, input logic [3:0] bm);
        digits_in   = d;
        dig_en      = en;
        lz_suppress = lz;
        blink_mask  = bm;
    endtask

    task automatic wait_frame();
        int n = 0;
        @(negedge clk);
        while (!frame_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_frame_start", 16'(frame_start), 16'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 16'(q.size()), 16'(0));
    endtask

    // Waits for the next frame, queues its four slot results, drives
    // blink_phase per slot (flipping it mid-DRIVE to show it is ignored
    // there), optionally changes digits_in mid-frame, then drains.
    task automatic run_frame(input exp_t e0, input exp_t e1, input exp_t e2, input exp_t e3,
                             input logic [3:0] ph, input int mid_slot, input logic [15:0] mid_d);
        wait_frame();
        q.push_back(e0);
        q.push_back(e1);
        q.push_back(e2);
        q.push_back(e3);
        for (int s = 0; s < 4; s++) begin
            blink_phase = ph[s];
            repeat (3) @(negedge clk);
            blink_phase = ~ph[s];
            if (s == mid_slot) digits_in = mid_d;
            if (s < 3) repeat (5) @(negedge clk);
        end
        drain();
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        set_in(16'h0000, 4'hF, 1'b0, 4'h0);
        blink_phase = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 16'(an), 16'(4'hF));
        check("rst_bcd", 16'(bcd_out), 16'(4'hB));
        check("rst_slot", 16'(slot_idx), 16'(0));
        @(posedge clk);
        #2 rst = 1'b0;

        // First frame after reset: zeros shown on every digit.
        run_frame(mk(0, 4'hE, 4'h0), mk(1, 4'hD, 4'h0), mk(2, 4'hB, 4'h0), mk(3, 4'h7, 4'h0),
                  4'b0000, -1, 16'h0);

        // Plain scan order.
        set_in(16'h1234, 4'hF, 1'b0, 4'h0);
        run_frame(mk(0, 4'hE, 4'h4), mk(1, 4'hD, 4'h3), mk(2, 4'hB, 4'h2), mk(3, 4'h7, 4'h1),
                  4'b0000, -1, 16'h0);

        // Leading-zero suppression.
        set_in(16'h0059, 4'hF, 1'b1, 4'h0);
        run_frame(mk(0, 4'hE, 4'h9), mk(1, 4'hD, 4'h5), mk(2, 4'hF, 4'hB), mk(3, 4'hF, 4'hB),
                  4'b0000, -1, 16'h0);
        set_in(16'h0000, 4'hF, 1'b1, 4'h0);
        run_frame(mk(0, 4'hE, 4'h0), mk(1, 4'hF, 4'hB), mk(2, 4'hF, 4'hB), mk(3, 4'hF, 4'hB),
                  4'b0000, -1, 16'h0);
        set_in(16'h0509, 4'hF, 1'b1, 4'h0);
        run_frame(mk(0, 4'hE, 4'h9), mk(1, 4'hD, 4'h0), mk(2, 4'hB, 4'h5), mk(3, 4'hF, 4'hB),
                  4'b0000, -1, 16'h0);

        // AM/PM codes pass through; 10-13 blank with anode still driven.
        set_in(16'hEF0A, 4'hF, 1'b0, 4'h0);
        run_frame(mk(0, 4'hE, 4'hB), mk(1, 4'hD, 4'h0), mk(2, 4'hB, 4'hF), mk(3, 4'h7, 4'hE),
                  4'b0000, -1, 16'h0);

        // Per-digit enables.
        set_in(16'h1234, 4'b0101, 1'b0, 4'h0);
        run_frame(mk(0, 4'hE, 4'h4), mk(1, 4'hF, 4'hB), mk(2, 4'hB, 4'h2), mk(3, 4'hF, 4'hB),
                  4'b0000, -1, 16'h0);

        // Mid-frame input change only shows from the next frame.
        set_in(16'h1234, 4'hF, 1'b0, 4'h0);
        run_frame(mk(0, 4'hE, 4'h4), mk(1, 4'hD, 4'h3), mk(2, 4'hB, 4'h2), mk(3, 4'h7, 4'h1),
                  4'b0000, 1, 16'h5678);
        run_frame(mk(0, 4'hE, 4'h8), mk(1, 4'hD, 4'h7), mk(2, 4'hB, 4'h6), mk(3, 4'h7, 4'h5),
                  4'b0000, -1, 16'h0);

        // Blinking digits 1 and 0.
        set_in(16'h1234, 4'hF, 1'b0, 4'b0011);
        run_frame(mk(0, 4'hF, 4'hB), mk(1, 4'hD, 4'h3), mk(2, 4'hB, 4'h2), mk(3, 4'h7, 4'h1),
                  4'b0101, -1, 16'h0);
        run_frame(mk(0, 4'hE, 4'h4), mk(1, 4'hF, 4'hB), mk(2, 4'hB, 4'h2), mk(3, 4'h7, 4'h1),
                  4'b1010, -1, 16'h0);

        // Reset mid-DRIVE of slot 2 blanks immediately, then restarts.
        set_in(16'h1234, 4'hF, 1'b0, 4'h0);
        wait_frame();
        q.push_back(mk(0, 4'hE, 4'h4));
        q.push_back(mk(1, 4'hD, 4'h3));
        q.push_back(mk(2, 4'hB, 4'h2));
        q.push_back(mk(3, 4'h7, 4'h1));
        repeat (20) @(negedge clk);
        check("pre_rst_an", 16'(an), 16'(4'hB));
        #2 rst = 1'b1;
        #1;
        check("async_rst_an", 16'(an), 16'(4'hF));
        check("async_rst_bcd", 16'(bcd_out), 16'(4'hB));
        check("async_rst_slot", 16'(slot_idx), 16'(0));
        q.delete();
        set_in(16'h5678, 4'hF, 1'b0, 4'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        run_frame(mk(0, 4'hE, 4'h8), mk(1, 4'hD, 4'h7), mk(2, 4'hB, 4'h6), mk(3, 4'h7, 4'h5),
                  4'b0000, -1, 16'h0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
